// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Each stage owns a contiguous group of lookahead slices; carry and lower sum bits ride the stage registers.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);

  localparam int NSLICE = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int SPS    = (STAGES > 0) ? NSLICE / STAGES : 1;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0 || STAGES < 1 ||
      STAGES > NSLICE || (NSLICE % ((STAGES > 0) ? STAGES : 1)) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH must be a multiple of CHUNK and WIDTH/CHUNK a multiple of STAGES");
  end

  // Returns {carry out, carry into top bit, sum} using two-level generate/propagate lookahead.
  function automatic logic [CHUNK+1:0] cla_slice(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
  endfunction

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic              ov_q, ov_d;
  logic              z_q, z_d;
  logic              adv;

  assign adv = !v_q[LAST] || ready_i;

  always_comb begin
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c;
    logic             cm;
    logic             v_in;
    logic [CHUNK+1:0] r;
    a_in = a_i;
    b_in = sub_i ? ~b_i : b_i;
    s_in = '0;
    c    = carry_i;
    v_in = valid_i;
    cm   = 1'b0;
    r    = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int m = 0; m < SPS; m++) begin
        r = cla_slice(a_in[(k*SPS+m)*CHUNK +: CHUNK], b_in[(k*SPS+m)*CHUNK +: CHUNK], c);
        s_in[(k*SPS+m)*CHUNK +: CHUNK] = r[CHUNK-1:0];
        cm = r[CHUNK];
        c  = r[CHUNK+1];
      end
      a_d[k] = a_in;
      b_d[k] = b_in;
      s_d[k] = s_in;
      c_d[k] = c;
      v_d[k] = v_in;
      a_in = a_q[k];
      b_in = b_q[k];
      s_in = s_q[k];
      c    = c_q[k];
      v_in = v_q[k];
    end
    // cm is left holding the carry into the MSB from the final slice of the last stage.
    ov_d = cm ^ c_d[LAST];
    z_d  = ~|s_d[LAST];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q  <= '0;
      c_q  <= '0;
      ov_q <= 1'b0;
      z_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= v_d;
      c_q  <= c_d;
      ov_q <= ov_d;
      z_q  <= z_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign ready_o    = adv;
  assign valid_o    = v_q[LAST];
  assign sum_o      = s_q[LAST];
  assign carry_o    = c_q[LAST];
  assign overflow_o = ov_q;
  assign zero_o     = z_q;
  assign negative_o = s_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe with directed, random-stall, reset and parameter cases
module tb_addsub_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, sub_i, carry_i, ready_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, valid_o, carry_o, overflow_o, zero_o, negative_o;
  logic [31:0] sum_o;

  logic        w_valid, w_ready_o, w_valid_o, w_carry, w_ov, w_z, w_n;
  logic [63:0] w_a, w_b, w_sum;
  logic        n_valid, n_ready_o, n_valid_o, n_carry, n_ov, n_z, n_n;
  logic [15:0] n_a, n_b, n_sum;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic rand_rdy = 1'b0;
  logic rdy_force = 1'b1;
  logic prev_stall = 1'b0;
  exp_t prev_out;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(32), .CHUNK(4), .STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o),
    .overflow_o(overflow_o), .zero_o(zero_o), .negative_o(negative_o)
  );

  addsub_pipe #(.WIDTH(64), .CHUNK(4), .STAGES(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .valid_i(w_valid), .ready_o(w_ready_o),
    .a_i(w_a), .b_i(w_b), .sub_i(1'b0), .carry_i(1'b0),
    .valid_o(w_valid_o), .ready_i(1'b1), .sum_o(w_sum), .carry_o(w_carry),
    .overflow_o(w_ov), .zero_o(w_z), .negative_o(w_n)
  );

  addsub_pipe #(.WIDTH(16), .CHUNK(4), .STAGES(1)) dut_n (
    .clk_i(clk), .rst_i(rst), .valid_i(n_valid), .ready_o(n_ready_o),
    .a_i(n_a), .b_i(n_b), .sub_i(1'b0), .carry_i(1'b0),
    .valid_o(n_valid_o), .ready_i(1'b1), .sum_o(n_sum), .carry_o(n_carry),
    .overflow_o(n_ov), .zero_o(n_z), .negative_o(n_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic ov,
                              input logic z, input logic n);
    exp_t e;
    e.sum = s; e.c = c; e.ov = ov; e.z = z; e.n = n;
    return e;
  endfunction

  // Reference: widened add and sign-rule overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    logic [31:0] be;
    logic [32:0] t;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {32'd0, cin};
    return mk(t[31:0], t[32], (a[31] == be[31]) && (t[31] != a[31]), t[31:0] == 32'd0, t[31]);
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic cin, input exp_t e);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    a_i = a; b_i = b; sub_i = sub; carry_i = cin; valid_i = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      n++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    else q.push_back(e);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic measure_latency(input string name, input int exp_edges);
    int e;
    e = 0;
    while (!valid_o && e < 10) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk(name, 64'(e), 64'(exp_edges));
  endtask

  always @(posedge clk) begin
    #1;
    ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("ready_o_vs_stall", 64'(ready_o), 64'(!(valid_o && !ready_i)));
      if (prev_stall) begin
        chk("hold_sum", 64'(sum_o), 64'(prev_out.sum));
        chk("hold_flags", 64'({carry_o, overflow_o, zero_o, negative_o}),
            64'({prev_out.c, prev_out.ov, prev_out.z, prev_out.n}));
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum %0h with empty scoreboard", sum_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 64'(sum_o), 64'(e.sum));
          chk("carry", 64'(carry_o), 64'(e.c));
          chk("overflow", 64'(overflow_o), 64'(e.ov));
          chk("zero", 64'(zero_o), 64'(e.z));
          chk("negative", 64'(negative_o), 64'(e.n));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = mk(sum_o, carry_o, overflow_o, zero_o, negative_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    valid_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; carry_i = 1'b0; ready_i = 1'b1;
    w_valid = 1'b0; w_a = '0; w_b = '0;
    n_valid = 1'b0; n_a = '0; n_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_sum_o", 64'(sum_o), 64'd0);
    chk("rst_flags", 64'({carry_o, overflow_o, zero_o, negative_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(ready_o), 64'd1);

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    measure_latency("latency_first", 1);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1));
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0));

    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      logic        rs, rc;
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("stream_drained", 64'(q.size()), 64'd0);
    rand_rdy = 1'b0;
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("two_in_flight_valid", 64'(valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid_o", 64'(valid_o), 64'd0);
    chk("async_rst_sum_o", 64'(sum_o), 64'd0);
    chk("async_rst_flags", 64'({carry_o, overflow_o, zero_o, negative_o}), 64'd0);
    q.delete();
    rdy_force = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_async_rst", 64'(ready_o), 64'd1);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, mk(32'h0123_4567, 1'b1, 1'b0, 1'b0, 1'b0));
    measure_latency("latency_after_rst", 1);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("post_rst_drained", 64'(q.size()), 64'd0);

    @(posedge clk);
    #1;
    w_a = '1; w_b = 64'd1; w_valid = 1'b1;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    n = 0;
    while (!w_valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w64_latency", 64'(n), 64'd3);
    chk("w64_sum", w_sum, 64'd0);
    chk("w64_carry", 64'(w_carry), 64'd1);

    n_a = '1; n_b = 16'd1; n_valid = 1'b1;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    n = 0;
    while (!n_valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n16_latency", 64'(n), 64'd0);
    chk("n16_sum", 64'(n_sum), 64'd0);
    chk("n16_carry", 64'(n_carry), 64'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor; successor to the fixed 32-bit chunked ripple adder in the ALU datapath.
- Builds its sum from CHUNK-bit carry-lookahead slices. Registers carry and partial results between STAGES pipeline stages so wide operands close timing.
- Adds a subtract mode, signed/unsigned status flags and a valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits per lookahead slice.
- STAGES, 2, pipeline depth; (WIDTH/CHUNK) must be divisible by STAGES; 1..WIDTH/CHUNK.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  input operands valid
- ready_o  out  1  block can accept input this cycle
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- sub_i  in  1  0: A+B+carry_i; 1: A+~B+carry_i
- carry_i  in  1  carry-in; set to 1 with sub_i=1 for plain A-B
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- sum_o  out  WIDTH  result, modulo 2^WIDTH
- carry_o  out  1  carry out of MSB; for subtraction, 1 = no borrow
- overflow_o  out  1  signed overflow
- zero_o  out  1  sum_o == 0
- negative_o  out  1  sum_o[WIDTH-1]

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits 0; valid_o=0, sum_o=0, carry_o=0, overflow_o=0, zero_o=0, negative_o=0. Reset mid-operation discards all in-flight transactions with no partial output. ready_o is 1 in the first cycle after reset deasserts.
- Stage k (0..STAGES-1) computes slices k*S..k*S+S-1, where S=(WIDTH/CHUNK)/STAGES.
  - Stage k takes its carry-in from the stage k-1 register; stage 0 uses carry_i.
  - Within a stage, slices ripple carry combinationally.
- Operand skew: upper operand bits (and sub_i-inverted B) are delayed through the stage registers until their stage. Lower result bits travel alongside to the output.
- B inversion is applied at capture in stage 0; the registered B is already effective B.
- Latency: a transaction accepted at edge N appears on the outputs after edge N+STAGES-1. Result is visible from cycle N+STAGES-1 and held until handshaked.
- Throughput: one transaction per cycle when ready_i=1.
- Handshake:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
  - Pipeline advance enable: adv = !valid_o || ready_i; all stages advance together; ready_o = adv.
  - No bubble collapsing: a stalled output freezes every stage.
  - ready_o may depend combinationally on ready_i; valid_o does not depend on valid_i.
- Output hold: while valid_o && !ready_i, sum_o and all flags are stable.
- Empty slots: a stage with valid=0 advances as a bubble; its data fields are don't-care. Outputs are don't-care when valid_o=0, except after reset (zeros).
- Flags, all from the final-stage result:
  - carry_o = carry out of bit WIDTH-1.
  - overflow_o = carry into MSB XOR carry out of MSB.
  - zero_o = ~|sum_o.
  - negative_o = sum_o[WIDTH-1].
- STAGES=1 degenerates to a single registered adder (latency 1) with identical handshake.
- Parameter violations stop elaboration with an error.

Test Plan:
- WIDTH=32, STAGES=2, ready_i=1: A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 -> after 2 edges sum=0, carry=1, zero=1, overflow=0, negative=0.
- Subtract: A=5, B=7, sub=1, cin=1 -> sum=0xFFFFFFFE, carry=0 (borrow), negative=1, overflow=0. A=0x80000000, B=1, sub=1, cin=1 -> sum=0x7FFFFFFF, overflow=1, carry=1.
- Signed add overflow plus carry chain across the stage boundary: A=0x7FFFFFFF, B=1 -> sum=0x80000000, overflow=1, negative=1. A=0x0000FFFF, B=1 -> sum=0x00010000, proving the carry crosses the register.
- Back-to-back stream of 20 random operand pairs with random sub/cin, ready_i toggling randomly -> outputs in order, match the reference model, no drops or duplicates. Result held stable while ready_i=0; ready_o=0 exactly when valid_o && !ready_i.
- Assert rst_i asynchronously (mid-clock) with 2 transactions in flight -> valid_o drops immediately, all outputs 0. After release, first new transaction emerges with correct value and latency 2.
- Parametric sweep: WIDTH=64/CHUNK=4/STAGES=4 and WIDTH=16/CHUNK=4/STAGES=1 -> A=all-ones, B=1 gives sum=0, carry=1, with latency 4 and 1 respectively.
